multi_sink: RTL and testbench
=============================

Name: multi_sink

Overview:
- Parametrised N-channel flit sink with per-channel throughput measurement and programmable backpressure.
- Terminates router/NI output channels in test fabrics.
- Captures accepted flits per channel, counts accepts over a fixed sample window, and publishes per-channel and total counts at each window end.
- Generates `busy` (none, alternating, pseudo-random, or hold) so downstream congestion can be emulated.

Parameters:
- N_CH, 4, number of input channels (1..16).
- DATA_W, `ADDR_SZ, flit width per channel.
- WIN_LOG2, 10, sample window length is 2**WIN_LOG2 cycles.
- CNT_W, 11, per-channel count width; saturating. Default WIN_LOG2+1 never saturates.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_CH  per-channel flit valid.
- data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- busy  out  N_CH  per-channel stall, registered.
- mode  in  2  backpressure mode: 00 none, 01 alternate, 10 random, 11 hold.
- stall_thresh  in  8  random-mode stall threshold.
- last_flit  out  N_CH*DATA_W  last accepted flit per channel.
- thru  out  N_CH*CNT_W  per-channel count of the last completed window.
- thru_total  out  CNT_W+4  sum of thru over all channels.
- thru_valid  out  1  one-cycle pulse when thru/thru_total update.
- seq_err  out  N_CH  sticky sequence error (optional feature; tied 0 when compiled out).

Behaviour:
- Reset values: busy = all ones; last_flit, thru, thru_total, thru_valid, seq_err = 0; window counter = 0; running counts = 0; LFSR = 16'hACE1; alternate toggle = 0.
- Accept: channel i accepts in a cycle where req[i]=1 and busy[i]=0, using the busy value registered at the previous edge. If req[i]=1 and busy[i]=1, nothing is captured; the source holds.
- Capture: on accept, last_flit[i] <= data[i] at that edge.
- Window counter:
  - Free-runs 0 .. 2**WIN_LOG2-1 and wraps.
  - A "terminal cycle" is a cycle where the counter equals the all-ones value.
- Non-terminal cycle: run[i] <= run[i] + acc[i], where acc[i] is the accept bit for channel i that cycle. Saturates at 2**CNT_W-1.
- Terminal cycle:
  - thru[i] <= sat(run[i] + acc[i]), so terminal-cycle accepts are counted, not dropped.
  - run[i] <= 0.
  - thru_total <= sum over i of the same saturated values.
  - thru_valid <= 1.
- thru_valid is 0 in every other cycle. First pulse is at edge 2**WIN_LOG2 after reset release.
- Busy generation, registered; mode is sampled each cycle and takes effect on the next busy value:
  - 00: busy <= 0.
  - 01: toggle flips every cycle; busy[i] <= toggle for all i, giving a 50% duty cycle.
  - 10: busy[i] <= (rotl(lfsr, 3*i)[7:0] < stall_thresh). stall_thresh=0 never stalls; 255 stalls 255/256.
  - 11: busy <= all ones.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every cycle regardless of mode, for deterministic sequences.
- Reset mid-window discards running counts. thru keeps its reset value 0 until the next full window.
- The block never drops an accepted flit. Capture plus count are the complete consumption.

Optional Feature:
- Macro: MULTI_SINK_SEQ_CHECK_EN.
- With it defined:
  - Per-channel expected-sequence register exp[i], reset 0.
  - On each accept, if data[i] != exp[i] then seq_err[i] <= 1 (sticky until reset).
  - exp[i] <= data[i] + 1 on every accept, so the check resynchronises after an error.
  - Widths wrap modulo 2**DATA_W.
- Without it: seq_err hard-wired 0; no exp registers are synthesised.

Test Plan:
- Reset then idle, mode=00, WIN_LOG2=4, N_CH=4 -> busy 4'hF during reset, 0 one edge after release; thru_valid pulses at cycles 16, 32; thru=0, thru_total=0.
- mode=00, req[0]=1 continuously, others 0 -> every window thru[0]=16, thru[1..3]=0, thru_total=16; last_flit[0] tracks data[0] each edge.
- mode=01, req=4'hF held -> each channel accepts 8 per 16-cycle window; thru_total=32; no capture on stalled cycles.
- mode=10, stall_thresh=0 then 255 -> thresh=0: busy always 0. thresh=255: accept count per channel matches a reference-model LFSR replay exactly.
- CNT_W=3, req[0]=1 continuous -> thru[0] saturates at 7, no wrap; terminal-cycle accept included when run<7.
- MULTI_SINK_SEQ_CHECK_EN: channel 2 sends 0,1,2,4,5 -> seq_err[2] sets on the edge accepting 4 and stays 1; other bits 0; reset clears it.

Source files
------------

// File: rtl/multi_sink.sv
// N-channel flit sink: per-channel capture, windowed throughput counters and programmable backpressure.
// Optional per-channel sequence checker enabled by defining MULTI_SINK_SEQ_CHECK_EN.

`ifndef ADDR_SZ
`define ADDR_SZ 16
`endif

module multi_sink #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned DATA_W   = `ADDR_SZ,
    parameter int unsigned WIN_LOG2 = 10,
    parameter int unsigned CNT_W    = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH*DATA_W-1:0]   data,
    output logic [N_CH-1:0]          busy,
    input  logic [1:0]               mode,
    input  logic [7:0]               stall_thresh,
    output logic [N_CH*DATA_W-1:0]   last_flit,
    output logic [N_CH*CNT_W-1:0]    thru,
    output logic [CNT_W+3:0]         thru_total,
    output logic                     thru_valid,
    output logic [N_CH-1:0]          seq_err
);

    typedef enum logic [1:0] {
        BP_NONE = 2'b00,
        BP_ALT  = 2'b01,
        BP_RAND = 2'b10,
        BP_HOLD = 2'b11
    } bp_mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;

    // Low byte of a 16-bit left rotation; used to give each channel its own view of the LFSR.
    function automatic logic [7:0] rot_lo(input logic [15:0] x, input int unsigned s);
        logic [15:0] r;
        r = (x << s) | (x >> (16 - s));
        return r[7:0];
    endfunction

    bp_mode_e                           mode_e;
    logic [WIN_LOG2-1:0]                win_q, win_d;
    logic                               terminal;
    logic [15:0]                        lfsr_q, lfsr_d;
    logic                               tog_q, tog_d;
    logic [N_CH-1:0]                    busy_q, busy_d;
    logic [N_CH-1:0]                    acc;
    logic [N_CH-1:0][DATA_W-1:0]        last_q, last_d;
    logic [N_CH-1:0][CNT_W-1:0]         run_q, run_d;
    logic [N_CH-1:0][CNT_W-1:0]         thru_q, thru_d;
    logic [N_CH-1:0][CNT_W-1:0]         sat_v;
    logic [CNT_W+3:0]                   total_q, total_d;
    logic                               valid_q, valid_d;

    assign mode_e   = bp_mode_e'(mode);
    assign terminal = &win_q;
    assign acc      = req & ~busy_q;

    always_comb begin
        win_d  = win_q + 1'b1;
        tog_d  = ~tog_q;
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_comb begin
        busy_d = '1;
        case (mode_e)
            BP_NONE: busy_d = '0;
            BP_ALT:  busy_d = {N_CH{tog_q}};
            BP_RAND: begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    busy_d[i] = rot_lo(lfsr_q, (3 * i) % 16) < stall_thresh;
                end
            end
            BP_HOLD: busy_d = '1;
            default: busy_d = '1;
        endcase
    end

    always_comb begin
        last_d = last_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (acc[i]) begin
                last_d[i] = data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Terminal-cycle accepts fold into the published count before the running count clears.
    always_comb begin
        sat_v   = run_q;
        run_d   = run_q;
        thru_d  = thru_q;
        total_d = total_q;
        valid_d = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (acc[i] && (run_q[i] != CNT_MAX)) begin
                sat_v[i] = run_q[i] + 1'b1;
            end
        end
        if (terminal) begin
            run_d   = '0;
            thru_d  = sat_v;
            valid_d = 1'b1;
            total_d = '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                total_d = total_d + {4'b0000, sat_v[i]};
            end
        end else begin
            run_d = sat_v;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            tog_q   <= 1'b0;
            busy_q  <= '1;
            last_q  <= '0;
            run_q   <= '0;
            thru_q  <= '0;
            total_q <= '0;
            valid_q <= 1'b0;
        end else begin
            win_q   <= win_d;
            lfsr_q  <= lfsr_d;
            tog_q   <= tog_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            run_q   <= run_d;
            thru_q  <= thru_d;
            total_q <= total_d;
            valid_q <= valid_d;
        end
    end

`ifdef MULTI_SINK_SEQ_CHECK_EN
    logic [N_CH-1:0][DATA_W-1:0] exp_q, exp_d;
    logic [N_CH-1:0]             serr_q, serr_d;

    // Expected value follows the received flit, so one gap flags once and the check resynchronises.
    always_comb begin
        exp_d  = exp_q;
        serr_d = serr_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (acc[i]) begin
                if (data[i*DATA_W +: DATA_W] != exp_q[i]) begin
                    serr_d[i] = 1'b1;
                end
                exp_d[i] = data[i*DATA_W +: DATA_W] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q  <= '0;
            serr_q <= '0;
        end else begin
            exp_q  <= exp_d;
            serr_q <= serr_d;
        end
    end

    assign seq_err = serr_q;
`else
    assign seq_err = '0;
`endif

    assign busy       = busy_q;
    assign last_flit  = last_q;
    assign thru       = thru_q;
    assign thru_total = total_q;
    assign thru_valid = valid_q;

endmodule

// File: tb/tb_multi_sink.sv
// Self-checking bench for multi_sink: vector table, hand sequences and random stimulus vs a reference model.

module tb_multi_sink;

    localparam int NC   = 4;
    localparam int DW   = 16;
    localparam int WL   = 4;
    localparam int WIN  = 1 << WL;
    localparam int CW   = 5;
    localparam int CWS  = 3;
    localparam int CAP  = (1 << CW) - 1;
    localparam int CAPS = (1 << CWS) - 1;
`ifdef MULTI_SINK_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic               clk;
    logic               reset;
    logic [NC-1:0]      req;
    logic [NC*DW-1:0]   data;
    logic [1:0]         mode;
    logic [7:0]         thresh;

    logic [NC-1:0]      busy, busy_s;
    logic [NC*DW-1:0]   last_flit, last_s;
    logic [NC*CW-1:0]   thru;
    logic [NC*CWS-1:0]  thru_s;
    logic [CW+3:0]      thru_total;
    logic [CWS+3:0]     total_s;
    logic               thru_valid, valid_s;
    logic [NC-1:0]      seq_err, seq_s;

    multi_sink #(.N_CH(NC), .DATA_W(DW), .WIN_LOG2(WL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .req(req), .data(data), .busy(busy), .mode(mode),
        .stall_thresh(thresh), .last_flit(last_flit), .thru(thru), .thru_total(thru_total),
        .thru_valid(thru_valid), .seq_err(seq_err));

    multi_sink #(.N_CH(NC), .DATA_W(DW), .WIN_LOG2(WL), .CNT_W(CWS)) dut_sat (
        .clk(clk), .reset(reset), .req(req), .data(data), .busy(busy_s), .mode(mode),
        .stall_thresh(thresh), .last_flit(last_s), .thru(thru_s), .thru_total(total_s),
        .thru_valid(valid_s), .seq_err(seq_s));

    always #5 clk = ~clk;

    int n_total, n_bad;

    // reference model state
    logic [15:0] m_lfsr;
    bit          m_tog;
    bit [NC-1:0] m_busy;
    int          m_win;
    int          m_run[NC];
    int          m_thru[NC];
    int          m_total;
    bit          m_valid;
    logic [15:0] m_last[NC];
    logic [15:0] m_exp[NC];
    bit [NC-1:0] m_serr;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] req;
        logic [7:0] thresh;
        int         exp_ch;
        int         exp_total;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] x, input int s);
        logic [31:0] d;
        d = {x, x};
        return d[31-s -: 16];
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1; m_tog = 0; m_busy = '1; m_win = 0; m_total = 0; m_valid = 0; m_serr = '0;
        for (int i = 0; i < NC; i++) begin
            m_run[i] = 0; m_thru[i] = 0; m_last[i] = '0; m_exp[i] = '0;
        end
    endtask

    task automatic tick();
        bit [NC-1:0]  acc;
        bit [NC-1:0]  nb;
        logic [15:0]  sl[NC];
        logic [15:0]  r;
        int           sum;
        for (int i = 0; i < NC; i++) begin
            acc[i] = req[i] && !m_busy[i];
            sl[i]  = data[i*DW +: DW];
        end
        case (mode)
            2'b00: nb = '0;
            2'b01: nb = {NC{m_tog}};
            2'b10: for (int i = 0; i < NC; i++) begin
                r = rotl(m_lfsr, (3 * i) % 16);
                nb[i] = (int'(r[7:0]) < int'(thresh));
            end
            default: nb = '1;
        endcase
        @(posedge clk); #1;
        sum = 0;
        for (int i = 0; i < NC; i++) begin
            if (m_win == WIN - 1) begin
                m_thru[i] = imin(m_run[i] + int'(acc[i]), CAP);
                sum += m_thru[i];
                m_run[i] = 0;
            end else begin
                m_run[i] = imin(m_run[i] + int'(acc[i]), CAP);
            end
            if (acc[i]) begin
                if (SEQ_EN && sl[i] != m_exp[i]) m_serr[i] = 1'b1;
                m_exp[i]  = sl[i] + 16'd1;
                m_last[i] = sl[i];
            end
        end
        m_valid = (m_win == WIN - 1);
        if (m_valid) m_total = sum;
        m_win  = (m_win + 1) % WIN;
        m_busy = nb;
        m_tog  = !m_tog;
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
        chk("busy", 64'(busy), 64'(m_busy));
        chk("busy_sat", 64'(busy_s), 64'(m_busy));
        chk("thru_valid", 64'(thru_valid), 64'(m_valid));
        chk("thru_valid_sat", 64'(valid_s), 64'(m_valid));
        chk("thru_total", 64'(thru_total), 64'(m_total));
        chk("seq_err", 64'(seq_err), 64'(m_serr));
        chk("seq_err_sat", 64'(seq_s), 64'(m_serr));
        for (int i = 0; i < NC; i++) begin
            chk($sformatf("thru[%0d]", i), 64'(thru[i*CW +: CW]), 64'(m_thru[i]));
            chk($sformatf("last_flit[%0d]", i), 64'(last_flit[i*DW +: DW]), 64'(m_last[i]));
            chk($sformatf("last_sat[%0d]", i), 64'(last_s[i*DW +: DW]), 64'(m_last[i]));
        end
    endtask

    task automatic step();
        data = {$urandom, $urandom};
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("async_rst_thru", 64'(thru), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'hF);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    int first_p, second_p, sat_sum;
    logic [15:0] seq_vals[5];

    initial begin
        vecs[0] = '{2'b00, 4'b0001, 8'd0,   16, 16};
        vecs[1] = '{2'b00, 4'b1111, 8'd0,   16, 64};
        vecs[2] = '{2'b01, 4'b1111, 8'd0,    8, 32};
        vecs[3] = '{2'b01, 4'b0101, 8'd0,    8, 16};
        vecs[4] = '{2'b11, 4'b1111, 8'd0,    0,  0};
        vecs[5] = '{2'b10, 4'b1111, 8'd0,   16, 64};
        vecs[6] = '{2'b10, 4'b1010, 8'd0,   16, 32};
        seq_vals = '{16'd0, 16'd1, 16'd2, 16'd4, 16'd5};

        n_total = 0; n_bad = 0;
        clk = 0; reset = 1; req = '0; data = '0; mode = 2'b00; thresh = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'hF);
        chk("rst_valid", 64'(thru_valid), 64'd0);
        chk("rst_thru", 64'(thru), 64'd0);
        chk("rst_total", 64'(thru_total), 64'd0);
        chk("rst_last", 64'(last_flit), 64'd0);
        chk("rst_seq_err", 64'(seq_err), 64'd0);
        reset = 0;
        model_reset();

        // idle after release: first pulses at edges WIN and 2*WIN
        first_p = -1; second_p = -1;
        for (int k = 1; k <= 3 * WIN; k++) begin
            step();
            if (k == 1) chk("busy_after_release", 64'(busy), 64'd0);
            if (thru_valid) begin
                if (first_p < 0) first_p = k;
                else if (second_p < 0) second_p = k;
            end
        end
        chk("first_pulse_edge", 64'(first_p), 64'(WIN));
        chk("second_pulse_edge", 64'(second_p), 64'(2 * WIN));

        // one full window under each table entry, then published counts
        foreach (vecs[v]) begin
            mode = vecs[v].mode; req = vecs[v].req; thresh = vecs[v].thresh;
            step();
            while (m_win != 0) step();
            repeat (WIN) step();
            sat_sum = 0;
            chk($sformatf("vec%0d_valid", v), 64'(thru_valid), 64'd1);
            for (int i = 0; i < NC; i++) begin
                chk($sformatf("vec%0d_thru[%0d]", v, i), 64'(thru[i*CW +: CW]),
                    64'(vecs[v].req[i] ? vecs[v].exp_ch : 0));
                chk($sformatf("vec%0d_sat_thru[%0d]", v, i), 64'(thru_s[i*CWS +: CWS]),
                    64'(vecs[v].req[i] ? imin(vecs[v].exp_ch, CAPS) : 0));
                sat_sum += vecs[v].req[i] ? imin(vecs[v].exp_ch, CAPS) : 0;
            end
            chk($sformatf("vec%0d_total", v), 64'(thru_total), 64'(vecs[v].exp_total));
            chk($sformatf("vec%0d_sat_total", v), 64'(total_s), 64'(sat_sum));
        end

        // six accepts ending on the terminal cycle: that last accept must be counted
        mode = 2'b00; req = '0;
        step();
        while (m_win != 0) step();
        for (int c = 0; c < WIN; c++) begin
            req = (c >= WIN - 6) ? 4'b0001 : 4'b0000;
            step();
        end
        chk("term_accept_thru0", 64'(thru[CW-1:0]), 64'd6);
        chk("term_accept_sat_thru0", 64'(thru_s[CWS-1:0]), 64'd6);

        // random-mode full stall threshold, followed by a mid-window reset
        mode = 2'b10; thresh = 8'd255; req = '1;
        repeat (3 * WIN) step();
        repeat (7) step();
        do_reset();
        mode = 2'b00;
        repeat (2 * WIN) step();

        // randomised traffic
        for (int k = 0; k < 400; k++) begin
            if (k % 8 == 0) begin
                mode   = 2'($urandom_range(0, 3));
                thresh = 8'($urandom);
            end
            req = 4'($urandom);
            step();
        end

        // sequence-gap on channel 2
        do_reset();
        mode = 2'b00; req = '0;
        step();
        req = 4'b0100;
        foreach (seq_vals[j]) begin
            data = {$urandom, $urandom};
            data[2*DW +: DW] = seq_vals[j];
            tick();
            if (j == 2) chk("seq_before_gap", 64'(seq_err), 64'd0);
            if (j >= 3) chk($sformatf("seq_after_gap%0d", j), 64'(seq_err), SEQ_EN ? 64'h4 : 64'h0);
        end
        req = '0;
        do_reset();
        chk("seq_cleared_by_reset", 64'(seq_err), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
